// File: rtl/frogger_pkg.sv
// ---------------------------------------------------------------------------
// frogger_pkg
//   Shared screen geometry and road-lane car defaults for the Frogger video
//   pipeline, plus elaboration-time helpers that validate lane parameters.
// ---------------------------------------------------------------------------
package frogger_pkg;

    typedef logic [9:0] coord_t;
    typedef logic [2:0] level_t;

    localparam int unsigned C_TILE_SIZE      = 32;
    localparam int unsigned C_H_VISIBLE_AREA = 640;
    localparam int unsigned C_V_VISIBLE_AREA = 480;

    // Sprite rows of the four road lanes (lane 1 nearest the frog start).
    localparam coord_t C_LINE_1_Y = 10'd416;
    localparam coord_t C_LINE_2_Y = 10'd384;
    localparam coord_t C_LINE_3_Y = 10'd352;
    localparam coord_t C_LINE_4_Y = 10'd320;

    // Packed lanes 4..1 (MSB first).
    localparam logic [11:0] C_LANE_PERIOD  = {3'd4, 3'd3, 3'd2, 3'd1};
    localparam logic [39:0] C_START_X      = {10'd480, 10'd320, 10'd160, 10'd0};
    localparam logic [3:0]  C_REVERSE_INIT = 4'b0101;

    // Every start X must be on screen and every pair of cars must be at
    // least one sprite width apart, measured around the wrapping screen.
    function automatic logic start_x_ok(input logic [39:0] sx,
                                        input int unsigned tile,
                                        input int unsigned hva);
        logic        ok;
        int unsigned a;
        int unsigned b;
        int unsigned d;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            a = {22'd0, sx[i*10 +: 10]};
            if (a >= hva) ok = 1'b0;
            for (int unsigned j = i + 1; j < 4; j++) begin
                b = {22'd0, sx[j*10 +: 10]};
                d = (a > b) ? a - b : b - a;
                if (d < tile || (d < hva && hva - d < tile)) ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic period_ok(input logic [11:0] lp);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < 4; i++) begin
            if (lp[i*3 +: 3] == 3'd0) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/car_lane_controller_car_lane.sv
// ---------------------------------------------------------------------------
// car_lane
//   One road lane: a frame counter that paces the car, the car X register and
//   the modulo-screen-width wrap logic.
// Ports
//   i_Clk, i_Rst_N   pixel clock, asynchronous active-low reset
//   i_Game_Reset     synchronous restart to START_X
//   i_Tick           registered frame strobe
//   i_Pause          hold counter and position
//   i_Step           pixels per step (1..8)
//   o_X              car left X, always < H_VISIBLE_AREA
// ---------------------------------------------------------------------------
module car_lane
    import frogger_pkg::*;
#(
    parameter int unsigned H_VISIBLE_AREA = C_H_VISIBLE_AREA,
    parameter logic [2:0]  PERIOD         = 3'd1,
    parameter logic [9:0]  START_X        = 10'd0,
    parameter logic        REVERSE        = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic       i_Game_Reset,
    input  logic       i_Tick,
    input  logic       i_Pause,
    input  logic [3:0] i_Step,
    output logic [9:0] o_X
);

    localparam logic [9:0] H_VIS = 10'(H_VISIBLE_AREA);
    localparam logic [2:0] LAST  = PERIOD - 3'd1;

    logic [2:0] r_Cnt;
    logic [9:0] r_X;
    logic [9:0] w_Step;
    logic [9:0] w_Sum;
    logic [9:0] w_Next_X;

    always_comb begin
        w_Step   = {6'd0, i_Step};
        w_Sum    = r_X + w_Step;
        w_Next_X = r_X;
        if (REVERSE) begin
            w_Next_X = (w_Sum >= H_VIS) ? w_Sum - H_VIS : w_Sum;
        end else if (r_X < w_Step) begin
            w_Next_X = r_X + H_VIS - w_Step;
        end else begin
            w_Next_X = r_X - w_Step;
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_Cnt <= '0;
            r_X   <= START_X;
        end else if (i_Game_Reset) begin
            r_Cnt <= '0;
            r_X   <= START_X;
        end else if (i_Tick && !i_Pause) begin
            if (r_Cnt == LAST) begin
                r_Cnt <= '0;
                r_X   <= w_Next_X;
            end else begin
                r_Cnt <= r_Cnt + 3'd1;
            end
        end
    end

    assign o_X = r_X;

endmodule

// File: rtl/car_lane_controller.sv
// ---------------------------------------------------------------------------
// car_lane_controller
//   X positions and directions of the four road-lane cars. Cars step only on
//   the frame strobe taken at the first blanking line, so positions never
//   change inside the visible area. Speed is level + 1 pixels per step.
// Ports
//   i_Clk, i_Rst_N           pixel clock, asynchronous active-low reset
//   i_H_Counter/i_V_Counter  VGA timing counters
//   i_Game_Reset             synchronous restart pulse (highest priority)
//   i_Level_Up               raise level by one, saturating at 7
//   i_Pause                  freeze all motion
//   o_Car_nX_Position        lane n car left X
//   o_Reverse                per-lane direction, bit n = lane n+1 moves right
//   o_Level                  current level 0..7
//   o_Frame_Tick             registered one-cycle frame strobe
// ---------------------------------------------------------------------------
module car_lane_controller
    import frogger_pkg::*;
#(
    parameter int unsigned TILE_SIZE      = C_TILE_SIZE,
    parameter int unsigned H_VISIBLE_AREA = C_H_VISIBLE_AREA,
    parameter int unsigned V_VISIBLE_AREA = C_V_VISIBLE_AREA,
    parameter logic [3:0]  REVERSE_INIT   = C_REVERSE_INIT,
    parameter logic [11:0] LANE_PERIOD    = C_LANE_PERIOD,
    parameter logic [39:0] START_X        = C_START_X
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic [9:0] i_H_Counter,
    input  logic [9:0] i_V_Counter,
    input  logic       i_Game_Reset,
    input  logic       i_Level_Up,
    input  logic       i_Pause,
    output logic [9:0] o_Car_1X_Position,
    output logic [9:0] o_Car_2X_Position,
    output logic [9:0] o_Car_3X_Position,
    output logic [9:0] o_Car_4X_Position,
    output logic [3:0] o_Reverse,
    output logic [2:0] o_Level,
    output logic       o_Frame_Tick
);

    localparam logic CFG_OK = start_x_ok(START_X, TILE_SIZE, H_VISIBLE_AREA)
                              && period_ok(LANE_PERIOD);

    logic       w_Tick_Raw;
    logic       r_Frame_Tick;
    logic [2:0] r_Level;
    logic [3:0] r_Reverse;
    logic [3:0] w_Step;
    logic [9:0] w_Car_X [4];

    assign w_Tick_Raw = (i_H_Counter == '0) && (i_V_Counter == 10'(V_VISIBLE_AREA));
    // Lanes see the registered level, so a level-up landing on the tick edge
    // only affects the following step.
    assign w_Step     = {1'b0, r_Level} + 4'd1;

    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            r_Frame_Tick <= 1'b0;
            r_Level      <= '0;
            r_Reverse    <= REVERSE_INIT;
        end else if (i_Game_Reset) begin
            r_Frame_Tick <= 1'b0;
            r_Level      <= '0;
            r_Reverse    <= REVERSE_INIT;
        end else begin
            r_Frame_Tick <= w_Tick_Raw;
            if (i_Level_Up && r_Level != 3'd7) begin
                r_Level <= r_Level + 3'd1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        car_lane #(
            .H_VISIBLE_AREA (H_VISIBLE_AREA),
            .PERIOD         (LANE_PERIOD[g*3 +: 3]),
            .START_X        (START_X[g*10 +: 10]),
            .REVERSE        (REVERSE_INIT[g])
        ) u_lane (
            .i_Clk        (i_Clk),
            .i_Rst_N      (i_Rst_N),
            .i_Game_Reset (i_Game_Reset),
            .i_Tick       (r_Frame_Tick),
            .i_Pause      (i_Pause),
            .i_Step       (w_Step),
            .o_X          (w_Car_X[g])
        );
    end

    a_cfg_ok: assert property (@(posedge i_Clk) CFG_OK);

    assign o_Car_1X_Position = w_Car_X[0];
    assign o_Car_2X_Position = w_Car_X[1];
    assign o_Car_3X_Position = w_Car_X[2];
    assign o_Car_4X_Position = w_Car_X[3];
    assign o_Reverse         = r_Reverse;
    assign o_Level           = r_Level;
    assign o_Frame_Tick      = r_Frame_Tick;

endmodule

// File: tb/tb_car_lane_controller.sv
module tb_car_lane_controller;

    localparam int H = 640;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] h_cnt, v_cnt;
    logic       game_reset, level_up, pause;
    logic [9:0] x1, x2, x3, x4;
    logic [3:0] reverse;
    logic [2:0] level;
    logic       frame_tick;
    logic [9:0] dut_x [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference configuration, lane index 0 = lane 1.
    int PERIOD [4] = '{1, 2, 3, 4};
    int START  [4] = '{0, 160, 320, 480};
    bit RIGHT  [4] = '{1, 0, 1, 0};

    // Reference model state.
    int m_x [4];
    int m_ticks [4];
    int m_level;
    bit m_tick_q;

    always #5 clk = ~clk;

    car_lane_controller dut (
        .i_Clk             (clk),
        .i_Rst_N           (rst_n),
        .i_H_Counter       (h_cnt),
        .i_V_Counter       (v_cnt),
        .i_Game_Reset      (game_reset),
        .i_Level_Up        (level_up),
        .i_Pause           (pause),
        .o_Car_1X_Position (x1),
        .o_Car_2X_Position (x2),
        .o_Car_3X_Position (x3),
        .o_Car_4X_Position (x4),
        .o_Reverse         (reverse),
        .o_Level           (level),
        .o_Frame_Tick      (frame_tick)
    );

    always_comb begin
        dut_x[0] = x1;
        dut_x[1] = x2;
        dut_x[2] = x3;
        dut_x[3] = x4;
    end

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_x[i]     = START[i];
            m_ticks[i] = 0;
        end
        m_level  = 0;
        m_tick_q = 0;
    endfunction

    // Drive one clock of inputs, then advance the model over that edge.
    task automatic cycle(input int h, input int v, input bit gr, input bit lu, input bit pz);
        int s;
        h_cnt = 10'(h); v_cnt = 10'(v);
        game_reset = gr; level_up = lu; pause = pz;
        @(posedge clk);
        if (gr) begin
            model_reset();
        end else begin
            s = m_level + 1;
            if (m_tick_q && !pz) begin
                for (int i = 0; i < 4; i++) begin
                    m_ticks[i]++;
                    if (m_ticks[i] % PERIOD[i] == 0)
                        m_x[i] = RIGHT[i] ? (m_x[i] + s) % H : (m_x[i] - s + H) % H;
                end
            end
            if (lu && m_level < 7) m_level++;
            m_tick_q = (h == 0 && v == 480);
        end
        #1;
    endtask

    task automatic idle(input bit gr, input bit lu, input bit pz);
        int h, v;
        h = $urandom_range(0, 799);
        v = $urandom_range(0, 524);
        if (h == 0 && v == 480) h = 1;
        cycle(h, v, gr, lu, pz);
    endtask

    task automatic tick(input bit lu, input bit pz);
        cycle(0, 480, 1'b0, lu, pz);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; h_cnt = '0; v_cnt = '0;
        game_reset = 0; level_up = 0; pause = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        // Near-miss counter values must not produce a tick.
        for (int k = 0; k < 12; k++) begin
            if (k == 3) cycle(0, 479, 0, 0, 0);
            else if (k == 5) cycle(1, 480, 0, 0, 0);
            else idle(0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dut_x[i] !== 10'(START[i])) begin
                    n_fail++;
                    $display("FAIL reset_x lane%0d: got %0d expected %0d", i + 1, dut_x[i], START[i]);
                end
            end
            n_checks++;
            if (level !== 3'd0 || reverse !== 4'b0101 || frame_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl: got level=%0d rev=%b tick=%b expected 0/0101/0", level, reverse, frame_tick);
            end
        end
    endtask

    task automatic test_first_tick();
        tick(0, 0);
        n_checks++;
        if (frame_tick !== 1'b1 || x1 !== 10'd0) begin
            n_fail++;
            $display("FAIL tick_latency1: got tick=%b x1=%0d expected 1/0", frame_tick, x1);
        end
        idle(0, 0, 0);
        n_checks++;
        if (frame_tick !== 1'b0 || x1 !== 10'd1 || x2 !== 10'd160 || x3 !== 10'd320 || x4 !== 10'd480) begin
            n_fail++;
            $display("FAIL tick_latency2: got tick=%b x=%0d/%0d/%0d/%0d expected 0 1/160/320/480",
                     frame_tick, x1, x2, x3, x4);
        end
        tick(0, 0);
        idle(0, 0, 0);
        n_checks++;
        if (x1 !== 10'd2 || x2 !== 10'd159 || x3 !== 10'd320) begin
            n_fail++;
            $display("FAIL second_tick: got x=%0d/%0d/%0d expected 2/159/320", x1, x2, x3);
        end
    endtask

    task automatic test_level();
        for (int k = 0; k < 10; k++) begin
            cycle(5, 5, 0, 1, 0);
            idle(0, 0, 0);
        end
        n_checks++;
        if (level !== 3'd7 || level !== 3'(m_level)) begin
            n_fail++;
            $display("FAIL level_saturate: got %0d expected 7", level);
        end
        cycle(5, 5, 1, 0, 0);
        cycle(5, 5, 0, 1, 0);
        cycle(5, 5, 0, 1, 0);
        tick(0, 0);
        cycle(5, 5, 0, 1, 0);  // level-up on the edge where the step happens
        n_checks++;
        if (x1 !== 10'd3 || level !== 3'd3) begin
            n_fail++;
            $display("FAIL level_up_on_tick: got x1=%0d level=%0d expected 3/3", x1, level);
        end
    endtask

    task automatic test_pause();
        logic [9:0] snap [4];
        int pulses;
        for (int i = 0; i < 4; i++) snap[i] = dut_x[i];
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick(0, 1);
            idle(0, 0, 1);
            if (frame_tick) pulses++;
            idle(0, 0, 1);
            if (frame_tick) pulses++;
        end
        // Strobe is visible on the cycle after each tick_raw, so sample there too.
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL pause_sample_window: got %0d off-slot pulses expected 0", pulses);
        end
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            cycle(0, 480, 0, 0, 1);
            if (frame_tick) pulses++;
            idle(0, 0, 1);
        end
        n_checks++;
        if (pulses !== 5) begin
            n_fail++;
            $display("FAIL pause_tick_pulses: got %0d expected 5", pulses);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dut_x[i] !== snap[i]) begin
                n_fail++;
                $display("FAIL pause_frozen lane%0d: got %0d expected %0d", i + 1, dut_x[i], snap[i]);
            end
        end
        tick(0, 0);
        idle(0, 0, 0);
        n_checks++;
        if (x1 !== 10'((snap[0] + m_level + 1) % H) || x1 !== 10'(m_x[0])) begin
            n_fail++;
            $display("FAIL pause_resume: got x1=%0d expected %0d", x1, m_x[0]);
        end
    endtask

    task automatic test_wrap();
        cycle(5, 5, 1, 0, 0);
        repeat (7) cycle(5, 5, 0, 1, 0);
        for (int k = 0; k < 100; k++) begin
            tick(0, 0);
            idle(0, 0, 0);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dut_x[i] !== 10'(m_x[i]) || dut_x[i] >= 10'd640) begin
                    n_fail++;
                    $display("FAIL wrap_l7 lane%0d step%0d: got %0d expected %0d", i + 1, k, dut_x[i], m_x[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        bit lu, pz, gr;
        int r;
        for (int k = 0; k < 1500; k++) begin
            r  = $urandom_range(0, 999);
            gr = (r < 3);
            lu = ($urandom_range(0, 39) == 0);
            pz = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) cycle(0, 480, gr, lu, pz);
            else idle(gr, lu, pz);
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (dut_x[i] !== 10'(m_x[i]) || dut_x[i] >= 10'd640) begin
                    n_fail++;
                    $display("FAIL random_x lane%0d cyc%0d: got %0d expected %0d", i + 1, k, dut_x[i], m_x[i]);
                end
            end
            n_checks++;
            if (level !== 3'(m_level) || frame_tick !== m_tick_q || reverse !== 4'b0101) begin
                n_fail++;
                $display("FAIL random_ctrl cyc%0d: got level=%0d tick=%b rev=%b expected %0d/%b/0101",
                         k, level, frame_tick, reverse, m_level, m_tick_q);
            end
        end
    endtask

    task automatic test_game_reset();
        repeat (3) begin
            tick(1, 0);
            idle(0, 0, 0);
        end
        tick(0, 0);
        cycle(5, 5, 1, 1, 0);  // game reset on the strobe edge together with level-up
        n_checks++;
        if (x1 !== 10'd0 || x2 !== 10'd160 || x3 !== 10'd320 || x4 !== 10'd480 ||
            level !== 3'd0 || frame_tick !== 1'b0) begin
            n_fail++;
            $display("FAIL game_reset: got x=%0d/%0d/%0d/%0d level=%0d tick=%b expected 0/160/320/480 0 0",
                     x1, x2, x3, x4, level, frame_tick);
        end
    endtask

    task automatic test_async_reset();
        repeat (4) begin
            tick(1, 0);
            idle(0, 0, 0);
        end
        tick(0, 0);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (x1 !== 10'd0 || x2 !== 10'd160 || x3 !== 10'd320 || x4 !== 10'd480 ||
            level !== 3'd0 || frame_tick !== 1'b0 || reverse !== 4'b0101) begin
            n_fail++;
            $display("FAIL async_reset: got x=%0d/%0d/%0d/%0d level=%0d tick=%b expected 0/160/320/480 0 0",
                     x1, x2, x3, x4, level, frame_tick);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        tick(0, 0);
        idle(0, 0, 0);
        n_checks++;
        if (x1 !== 10'd1 || x2 !== 10'd160 || x1 !== 10'(m_x[0])) begin
            n_fail++;
            $display("FAIL async_resume: got x1=%0d x2=%0d expected 1/160", x1, x2);
        end
    endtask

    initial begin
        test_reset();
        test_first_tick();
        test_level();
        test_pause();
        test_wrap();
        test_random();
        test_game_reset();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
